// File: rtl/oppm_pkg.sv
// Shared types and helpers for the OPPM demodulator and its width checker.
package oppm_pkg;

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_e;

  // Slot-index width for the default 4-slot (N=2) frame.
  localparam int SLOT_W = 2;

  function automatic int frame_len(input int n, input int l);
    return (1 << n) * l;
  endfunction

endpackage

// File: rtl/oppm_width_checker.sv
// Edge detector plus pulse high-time measurement; strobes width_err when a
// pulse is too short (on its fall) or too long (once, while still high).
module oppm_width_checker #(
  parameter int PULSE_CT = 4,
  parameter int TOL      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic rise,
  output logic fall,
  output logic width_err
);
  localparam int HI_MAX = PULSE_CT + TOL + 1;
  localparam int HI_MIN = PULSE_CT - TOL;
  localparam int CW     = $clog2(HI_MAX + 1);

  logic          pulse_q;
  logic [CW-1:0] hi_cnt;

  assign rise = pulse & ~pulse_q;
  assign fall = ~pulse & pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q   <= 1'b0;
      hi_cnt    <= '0;
      width_err <= 1'b0;
    end else begin
      pulse_q   <= pulse;
      width_err <= 1'b0;
      if (rise) begin
        hi_cnt <= CW'(1);
      end else if (pulse && hi_cnt != CW'(HI_MAX)) begin
        hi_cnt <= hi_cnt + CW'(1);
        // Saturation is reached only once per pulse, so this strobes once.
        if (hi_cnt == CW'(HI_MAX - 1)) width_err <= 1'b1;
      end
      if (fall && int'(hi_cnt) < HI_MIN) width_err <= 1'b1;
    end
  end

endmodule

// File: rtl/oppm_demodulator.sv
// OPPM symbol demodulator: locks to the first pulse, emits one symbol per frame.
// Define OPPM_DEMOD_SYNC_EN to add a 2-flop input synchronizer on pulse.
module oppm_demodulator
  import oppm_pkg::*;
#(
  parameter int PULSE_CT = 4,
  parameter int N        = 2,
  parameter int L        = 8,
  parameter int TOL      = 1,
  parameter int MISS_MAX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse,
  input  logic         resync,
  output logic [N-1:0] sym,
  output logic         sym_valid,
  output logic         sym_err,
  output logic         sym_erase,
  output logic         width_err,
  output logic         locked
);
  localparam int F  = frame_len(N, L);
  localparam int TW = $clog2(F);
  localparam int MW = $clog2(MISS_MAX + 1);

  logic pulse_s, rise, fall;

`ifdef OPPM_DEMOD_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pulse};
  end
  assign pulse_s = sync_q[1];
`else
  assign pulse_s = pulse;
`endif

  oppm_width_checker #(.PULSE_CT(PULSE_CT), .TOL(TOL)) u_width (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse     (pulse_s),
    .rise      (rise),
    .fall      (fall),
    .width_err (width_err)
  );

  state_e        state, state_d;
  logic [TW-1:0] t, t_d;
  logic          hit, hit_d, multi, multi_d;
  logic [N-1:0]  cap, cap_d, slot, frame_sym;
  logic [MW-1:0] miss, miss_d, miss_inc;
  logic [N-1:0]  sym_d;
  logic          err_d, erase_d, valid_d, frame_hit, frame_multi;

  assign slot        = N'(t / TW'(L));
  assign miss_inc    = miss + MW'(1);
  // A rise on the last tick still belongs to the ending frame.
  assign frame_hit   = hit | rise;
  assign frame_multi = multi | (hit & rise);
  assign frame_sym   = hit ? cap : slot;
  assign locked      = (state == LOCK);

  always_comb begin
    state_d = state;
    t_d     = t;
    hit_d   = hit;
    multi_d = multi;
    cap_d   = cap;
    miss_d  = miss;
    sym_d   = sym;
    err_d   = sym_err;
    erase_d = sym_erase;
    valid_d = 1'b0;
    if (resync) begin
      state_d = HUNT;
      t_d     = '0;
      hit_d   = 1'b0;
      multi_d = 1'b0;
      miss_d  = '0;
    end else if (state == HUNT) begin
      t_d = '0;
      if (rise) begin
        // Lock pulse sits at the centre of slot 0, giving +/-L/2 margin.
        state_d = LOCK;
        t_d     = TW'(L / 2 + 1);
        hit_d   = 1'b1;
        multi_d = 1'b0;
        cap_d   = '0;
      end
    end else begin
      if (rise) begin
        if (hit) multi_d = 1'b1;
        else begin
          hit_d = 1'b1;
          cap_d = slot;
        end
      end
      if (t == TW'(F - 1)) begin
        t_d     = '0;
        valid_d = 1'b1;
        hit_d   = 1'b0;
        multi_d = 1'b0;
        if (frame_hit) begin
          sym_d   = frame_sym;
          err_d   = frame_multi;
          erase_d = 1'b0;
          miss_d  = '0;
        end else begin
          sym_d   = '0;
          err_d   = 1'b0;
          erase_d = 1'b1;
          miss_d  = miss_inc;
          if (miss_inc == MW'(MISS_MAX)) begin
            state_d = HUNT;
            miss_d  = '0;
          end
        end
      end else begin
        t_d = t + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      t         <= '0;
      hit       <= 1'b0;
      multi     <= 1'b0;
      cap       <= '0;
      miss      <= '0;
      sym       <= '0;
      sym_err   <= 1'b0;
      sym_erase <= 1'b0;
      sym_valid <= 1'b0;
    end else begin
      state     <= state_d;
      t         <= t_d;
      hit       <= hit_d;
      multi     <= multi_d;
      cap       <= cap_d;
      miss      <= miss_d;
      sym       <= sym_d;
      sym_err   <= err_d;
      sym_erase <= erase_d;
      sym_valid <= valid_d;
    end
  end

endmodule
